llc_tag_lookup: RTL and testbench
=================================

# llc_tag_lookup

- Lookup/update stage directly downstream of the address-split stage in the LLC simulator.
- Takes one request at a time: decoded index and tag plus a trace opcode.
- Checks every way of the addressed set, picks a victim on a miss (tree pseudo-LRU), applies the MESI transition and issues one response pulse with hit status and required bus actions.
- Holds the tag, MESI and PLRU arrays in flops.

## Interface
Parameters:
- INDEX_BITS, 4: set index width; number of sets is 2^INDEX_BITS.
- TAG_BITS, 22: tag width.
- WAYS, 4: associativity; power of 2, range 2..16. Each set holds WAYS-1 PLRU bits.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  4  trace opcode:
  - 0 read
  - 1 write
  - 2 instruction fetch
  - 3 snoop invalidate
  - 4 snoop read
  - 6 snoop RWIM
  - 8 clear
  - any other value is a no-op.
- req_index  in  INDEX_BITS  set index.
- req_tag  in  TAG_BITS  tag.
- req_snoop_hit  in  1  for read misses: another cache holds the line.
- rsp_valid  out  1  one-cycle response strobe; there is no backpressure.
- rsp_hit  out  1  tag matched a non-Invalid way.
- rsp_way  out  $clog2(WAYS)  way that hit or was filled.
- rsp_bus_rd, rsp_bus_rwim, rsp_bus_inv  out  1 each  bus operation to issue.
- rsp_writeback  out  1  a Modified line must be written back.
- rsp_wb_tag  out  TAG_BITS  tag of the line being written back.
- rsp_snoop_result  out  2  response to a snoop: 0 NOHIT, 1 HIT, 2 HITM.

## Operation
MESI encoding: I=00, S=01, E=10, M=11.

FSM states are IDLE, LOOKUP, UPDATE and CLEAR.
- IDLE: asserts req_ready. `req_valid & req_ready` latches op, index, tag and snoop_hit. Op 8 goes to CLEAR; every other op goes to LOOKUP.
- LOOKUP: compares the latched tag against all ways of the latched set and registers hit, hit way and victim way. Then goes to UPDATE.
- UPDATE: writes the arrays, drives rsp_valid=1 with all rsp_* fields, then returns to IDLE.
- CLEAR: a set counter walks 0..2^INDEX_BITS-1, one set per cycle. For each set it writes all ways to I and the PLRU bits to 0. It pulses rsp_valid with every flag 0 on the last set, then returns to IDLE.

Victim choice on a miss:
- The lowest-numbered way in state I wins.
- If no way is I, the tree-PLRU victim is used.
- PLRU node bit 0 means the victim lies in the left (lower) subtree.
- A touch sets every node on the path so that it points away from the accessed way.
- A set whose PLRU bits are all 0 gives way 0 as victim.

Processor ops (touch PLRU on hit and on fill):
- Read or fetch, hit: state unchanged.
- Read or fetch, miss:
  - rsp_bus_rd=1.
  - If the victim is M: rsp_writeback=1 and rsp_wb_tag = victim tag.
  - Install the tag as S if req_snoop_hit=1, otherwise as E.
- Write, hit:
  - S→M with rsp_bus_inv=1.
  - E→M and M→M with no bus operation.
- Write, miss: rsp_bus_rwim=1, writeback if the victim is M, install as M.

Snoop ops (never touch PLRU, never fill):
- Snoop invalidate: S→I, result HIT. Any other state is unchanged with result NOHIT.
- Snoop read:
  - E→S, result HIT.
  - S stays S, result HIT.
  - M→S, result HITM with rsp_writeback=1.
- Snoop RWIM:
  - E or S→I, result HIT.
  - M→I, result HITM with rsp_writeback=1.
- Snoop miss: result NOHIT, no change.

Unknown ops: rsp_valid still pulses, with all flags 0 and the arrays unchanged.

## Timing
- Request accepted at edge T; rsp_valid is high in cycle T+2; req_ready returns high in cycle T+3.
- Peak throughput is one request per 3 cycles.
- A clear accepted at T pulses rsp_valid in cycle T+2^INDEX_BITS and is ready again the cycle after.
- Array writes made in UPDATE are visible to a request accepted in the following IDLE cycle. There is no read-after-write hazard.
- Reset values: req_ready=1 after release; rsp_valid=0; every other rsp_* output is 0.
- Reset also sets all MESI entries to I, all tags to 0 and all PLRU bits to 0.
- Reset asserted in any state, including mid-CLEAR or mid-UPDATE, aborts the operation. No response pulse is produced and the state is IDLE on the next cycle.
- req_valid while req_ready=0 is ignored; the upstream stage must hold the request.

## Configuration
- LLC_STATS_EN defined: adds four 32-bit outputs, stat_reads, stat_writes, stat_hits and stat_misses.
  - Reads count ops 0 and 2; writes count op 1.
  - Hits and misses count processor ops only.
  - Counters increment in UPDATE, reset to 0 with rst_n and saturate at 0xFFFF_FFFF.
  - Clear does not zero them.
- LLC_STATS_EN not defined: the ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- Reset, then read index 3 tag 0x1A with snoop_hit=0 → rsp at T+2: hit=0, way=0, bus_rd=1. Repeat the read → hit=1, way=0, no bus op, state E.
- Write to an E line → hit=1, no bus op, state M. Then snoop read of the same line → result HITM, writeback=1, state S.
- Fill 4 distinct tags into set 5 (ways 0–3), touch way 0, then read a fifth tag → victim way 2 (tree PLRU), bus_rd=1. Writeback=1 only if way 2 was M.
- Snoop RWIM and snoop invalidate hitting an S line → state I with result HIT; a later read of that line misses. A snoop to an absent tag → NOHIT with the PLRU bits unchanged.
- Clear op with INDEX_BITS=4 → req_ready low for 16 cycles, a single rsp_valid, then every lookup misses and fills way 0.
- Assert rst_n=0 during CLEAR at set 7 → no rsp_valid, IDLE next cycle, all lines I. With LLC_STATS_EN, the counters read 0.

Source files
------------

// File: rtl/llc_tag_lookup.sv
// LLC tag/MESI/PLRU lookup-update stage: IDLE -> LOOKUP -> UPDATE, or a CLEAR walk.
// Define LLC_STATS_EN to add saturating read/write/hit/miss counters.
module llc_tag_lookup #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 22,
  parameter int WAYS       = 4,
  localparam int WW        = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [INDEX_BITS-1:0] req_index,
  input  logic [TAG_BITS-1:0]   req_tag,
  input  logic                  req_snoop_hit,
  output logic                  rsp_valid,
  output logic                  rsp_hit,
  output logic [WW-1:0]         rsp_way,
  output logic                  rsp_bus_rd,
  output logic                  rsp_bus_rwim,
  output logic                  rsp_bus_inv,
  output logic                  rsp_writeback,
  output logic [TAG_BITS-1:0]   rsp_wb_tag,
  output logic [1:0]            rsp_snoop_result
`ifdef LLC_STATS_EN
  ,
  output logic [31:0]           stat_reads,
  output logic [31:0]           stat_writes,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses
`endif
);

  localparam int SETS = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE, S_LOOKUP, S_UPDATE, S_CLEAR
  } state_t;

  typedef enum logic [1:0] {
    MI = 2'b00, MS = 2'b01, ME = 2'b10, MM = 2'b11
  } mesi_t;

  state_t                r_state, w_nstate;
  logic [3:0]            r_op;
  logic [INDEX_BITS-1:0] r_idx;
  logic [TAG_BITS-1:0]   r_tag;
  logic                  r_sh;
  logic                  r_hit;
  logic [WW-1:0]         r_hway;
  logic [WW-1:0]         r_vway;
  logic [INDEX_BITS-1:0] r_cnt;

  logic [TAG_BITS-1:0]   r_tags [SETS][WAYS];
  mesi_t                 r_mesi [SETS][WAYS];
  logic [WAYS-2:0]       r_plru [SETS];

  logic [WAYS-1:0]       w_match;
  logic [WAYS-1:0]       w_free;
  logic                  w_pr, w_pw, w_si, w_sr, w_sw;
  mesi_t                 w_cur, w_vst, w_new;
  logic [WW-1:0]         w_way;
  logic                  w_wr_mesi, w_wr_tag, w_touch;
  logic                  w_hit, w_rd, w_rwim, w_inv, w_wb;
  logic [TAG_BITS-1:0]   w_wbt;
  logic [1:0]            w_snp;
  logic                  w_upd, w_clr_last;

  function automatic logic [WW-1:0] lowest(
    input logic [WAYS-1:0] v
  );
    logic [WW-1:0] r;
    r = '0;
    for (int i = WAYS - 1; i >= 0; i--)
      if (v[i]) r = WW'(i);
    return r;
  endfunction

  // Heap-ordered tree: node n has children 2n+1 (lower) and 2n+2.
  function automatic logic [WW-1:0] plru_victim(
    input logic [WAYS-2:0] p
  );
    int n;
    n = 0;
    for (int l = 0; l < WW; l++)
      n = 2 * n + 1 + int'(p[n]);
    return WW'(n - (WAYS - 1));
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(
    input logic [WAYS-2:0] p,
    input logic [WW-1:0]   w
  );
    logic [WAYS-2:0] q;
    int n;
    q = p;
    n = 0;
    for (int l = 0; l < WW; l++) begin
      q[n] = ~w[WW-1-l];
      n = 2 * n + 1 + int'(w[WW-1-l]);
    end
    return q;
  endfunction

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_IDLE:
        if (req_valid)
          w_nstate = (req_op == 4'd8) ? S_CLEAR : S_LOOKUP;
      S_LOOKUP: w_nstate = S_UPDATE;
      S_UPDATE: w_nstate = S_IDLE;
      S_CLEAR:
        if (r_cnt == '1) w_nstate = S_IDLE;
      default:  w_nstate = S_IDLE;
    endcase
  end

  always_comb begin
    w_match = '0;
    w_free  = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_free[w]  = (r_mesi[r_idx][w] == MI);
      w_match[w] = (r_mesi[r_idx][w] != MI) &&
                   (r_tags[r_idx][w] == r_tag);
    end
  end

  always_comb begin
    w_pr      = (r_op == 4'd0) || (r_op == 4'd2);
    w_pw      = (r_op == 4'd1);
    w_si      = (r_op == 4'd3);
    w_sr      = (r_op == 4'd4);
    w_sw      = (r_op == 4'd6);
    w_cur     = r_mesi[r_idx][r_hway];
    w_vst     = r_mesi[r_idx][r_vway];
    w_way     = r_hit ? r_hway : r_vway;
    w_new     = w_cur;
    w_wr_mesi = 1'b0;
    w_wr_tag  = 1'b0;
    w_touch   = 1'b0;
    w_hit     = 1'b0;
    w_rd      = 1'b0;
    w_rwim    = 1'b0;
    w_inv     = 1'b0;
    w_wb      = 1'b0;
    w_wbt     = '0;
    w_snp     = 2'd0;
    unique case (1'b1)
      w_pr, w_pw: begin
        w_hit   = r_hit;
        w_touch = 1'b1;
        if (r_hit) begin
          if (w_pw) begin
            w_inv     = (w_cur == MS);
            w_wr_mesi = 1'b1;
            w_new     = MM;
          end
        end else begin
          w_rd      = w_pr;
          w_rwim    = w_pw;
          w_wr_tag  = 1'b1;
          w_wr_mesi = 1'b1;
          w_new     = w_pw ? MM : (r_sh ? MS : ME);
          w_wb      = (w_vst == MM);
          w_wbt     = w_wb ? r_tags[r_idx][r_vway] : '0;
        end
      end
      w_si, w_sr, w_sw: begin
        w_hit = r_hit;
        if (r_hit) begin
          w_wr_mesi = 1'b1;
          if (w_si) begin
            w_new = (w_cur == MS) ? MI : w_cur;
            w_snp = (w_cur == MS) ? 2'd1 : 2'd0;
          end else begin
            w_new = w_sr ? MS : MI;
            w_snp = (w_cur == MM) ? 2'd2 : 2'd1;
          end
          w_wb  = (w_cur == MM) && !w_si;
          w_wbt = w_wb ? r_tag : '0;
        end
      end
      default: ;
    endcase
  end

  // rst_n gates the strobe so an aborted UPDATE/CLEAR never responds.
  assign w_upd      = rst_n && (r_state == S_UPDATE);
  assign w_clr_last = rst_n && (r_state == S_CLEAR) && (r_cnt == '1);

  assign req_ready        = (r_state == S_IDLE);
  assign rsp_valid        = w_upd || w_clr_last;
  assign rsp_hit          = w_upd && w_hit;
  assign rsp_way          = (w_upd && w_hit) ? r_hway :
                            (w_upd && (w_pr || w_pw)) ? r_vway : '0;
  assign rsp_bus_rd       = w_upd && w_rd;
  assign rsp_bus_rwim     = w_upd && w_rwim;
  assign rsp_bus_inv      = w_upd && w_inv;
  assign rsp_writeback    = w_upd && w_wb;
  assign rsp_wb_tag       = w_upd ? w_wbt : '0;
  assign rsp_snoop_result = w_upd ? w_snp : 2'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_idx   <= '0;
      r_tag   <= '0;
      r_sh    <= 1'b0;
      r_hit   <= 1'b0;
      r_hway  <= '0;
      r_vway  <= '0;
      r_cnt   <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_plru[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_mesi[s][w] <= MI;
          r_tags[s][w] <= '0;
        end
      end
    end else begin
      r_state <= w_nstate;
      if (r_state == S_IDLE && req_valid) begin
        r_op  <= req_op;
        r_idx <= req_index;
        r_tag <= req_tag;
        r_sh  <= req_snoop_hit;
      end
      if (r_state == S_LOOKUP) begin
        r_hit  <= |w_match;
        r_hway <= lowest(w_match);
        r_vway <= (|w_free) ? lowest(w_free)
                            : plru_victim(r_plru[r_idx]);
      end
      if (r_state == S_UPDATE) begin
        if (w_wr_mesi) r_mesi[r_idx][w_way] <= w_new;
        if (w_wr_tag)  r_tags[r_idx][w_way] <= r_tag;
        if (w_touch)
          r_plru[r_idx] <= plru_touch(r_plru[r_idx], w_way);
      end
      if (r_state == S_CLEAR) begin
        r_plru[r_cnt] <= '0;
        for (int w = 0; w < WAYS; w++)
          r_mesi[r_cnt][w] <= MI;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef LLC_STATS_EN
  logic w_sproc;
  assign w_sproc = (r_state == S_UPDATE) && (w_pr || w_pw);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (w_sproc) begin
      if (w_pr && stat_reads != '1)
        stat_reads <= stat_reads + 1'b1;
      if (w_pw && stat_writes != '1)
        stat_writes <= stat_writes + 1'b1;
      if (r_hit && stat_hits != '1)
        stat_hits <= stat_hits + 1'b1;
      if (!r_hit && stat_misses != '1)
        stat_misses <= stat_misses + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_llc_tag_lookup.sv
// Bench for llc_tag_lookup: directed requests checked every cycle
// against a set/way/tree model held in the bench.
module tb_llc_tag_lookup;

  localparam int NS = 16;
  localparam int NW = 4;

  typedef struct packed {
    logic        hit;
    logic [1:0]  way;
    logic        rd;
    logic        rwim;
    logic        inv;
    logic        wb;
    logic [21:0] wbt;
    logic [1:0]  snp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [3:0]  req_index;
  logic [21:0] req_tag;
  logic        req_snoop_hit;
  logic        rsp_valid;
  logic        rsp_hit;
  logic [1:0]  rsp_way;
  logic        rsp_bus_rd;
  logic        rsp_bus_rwim;
  logic        rsp_bus_inv;
  logic        rsp_writeback;
  logic [21:0] rsp_wb_tag;
  logic [1:0]  rsp_snoop_result;
`ifdef LLC_STATS_EN
  logic [31:0] stat_reads, stat_writes;
  logic [31:0] stat_hits, stat_misses;
`endif

  llc_tag_lookup dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_index        (req_index),
    .req_tag          (req_tag),
    .req_snoop_hit    (req_snoop_hit),
    .rsp_valid        (rsp_valid),
    .rsp_hit          (rsp_hit),
    .rsp_way          (rsp_way),
    .rsp_bus_rd       (rsp_bus_rd),
    .rsp_bus_rwim     (rsp_bus_rwim),
    .rsp_bus_inv      (rsp_bus_inv),
    .rsp_writeback    (rsp_writeback),
    .rsp_wb_tag       (rsp_wb_tag),
    .rsp_snoop_result (rsp_snoop_result)
`ifdef LLC_STATS_EN
    ,
    .stat_reads       (stat_reads),
    .stat_writes      (stat_writes),
    .stat_hits        (stat_hits),
    .stat_misses      (stat_misses)
`endif
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   exp_cyc = -10;
  int   ready_cyc = 0;
  bit   chk_en = 1'b0;
  exp_t exp_r;
  exp_t e;
  logic ev;

  // Model: state 0=I 1=S 2=E 3=M; pl[node]=0 means victim is lower half.
  logic [21:0] m_tag [NS][NW];
  int          m_st  [NS][NW];
  int          m_pl  [NS][NW-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               nm, act, want, cyc);
    end
  endtask

  function automatic void m_reset();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        m_tag[s][w] = '0;
        m_st[s][w]  = 0;
        if (w < NW - 1) m_pl[s][w] = 0;
      end
  endfunction

  function automatic int m_victim(input int s);
    int lo, hi, mid, nd;
    lo = 0; hi = NW; nd = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (m_pl[s][nd] == 0) begin
        hi = mid; nd = 2 * nd + 1;
      end else begin
        lo = mid; nd = 2 * nd + 2;
      end
    end
    return lo;
  endfunction

  function automatic void m_touch(input int s, input int w);
    int lo, hi, mid, nd;
    lo = 0; hi = NW; nd = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin
        m_pl[s][nd] = 1; hi = mid; nd = 2 * nd + 1;
      end else begin
        m_pl[s][nd] = 0; lo = mid; nd = 2 * nd + 2;
      end
    end
  endfunction

  function automatic exp_t m_apply(input logic [3:0] op,
                                   input int s,
                                   input logic [21:0] tg,
                                   input logic sh);
    exp_t r;
    int hw, v, st;
    r = '0;
    hw = -1;
    for (int w = NW - 1; w >= 0; w--)
      if (m_st[s][w] != 0 && m_tag[s][w] == tg) hw = w;
    if (op == 0 || op == 1 || op == 2) begin
      if (hw >= 0) begin
        r.hit = 1; r.way = 2'(hw);
        if (op == 1) begin
          r.inv = (m_st[s][hw] == 1);
          m_st[s][hw] = 3;
        end
        m_touch(s, hw);
      end else begin
        v = -1;
        for (int w = NW - 1; w >= 0; w--)
          if (m_st[s][w] == 0) v = w;
        if (v < 0) v = m_victim(s);
        r.way = 2'(v);
        if (m_st[s][v] == 3) begin
          r.wb = 1; r.wbt = m_tag[s][v];
        end
        if (op == 1) begin
          r.rwim = 1; m_st[s][v] = 3;
        end else begin
          r.rd = 1; m_st[s][v] = sh ? 1 : 2;
        end
        m_tag[s][v] = tg;
        m_touch(s, v);
      end
    end else if (op == 3 || op == 4 || op == 6) begin
      if (hw >= 0) begin
        r.hit = 1; r.way = 2'(hw);
        st = m_st[s][hw];
        if (op == 3) begin
          if (st == 1) begin
            m_st[s][hw] = 0; r.snp = 1;
          end
        end else begin
          r.snp = (st == 3) ? 2 : 1;
          r.wb  = (st == 3);
          r.wbt = (st == 3) ? tg : '0;
          m_st[s][hw] = (op == 4) ? 1 : 0;
        end
      end
    end else if (op == 8) begin
      for (int a = 0; a < NS; a++)
        for (int w = 0; w < NW; w++) begin
          m_st[a][w] = 0;
          if (w < NW - 1) m_pl[a][w] = 0;
        end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      ev = (cyc == exp_cyc);
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      chk("req_ready", 32'(req_ready), 32'(cyc >= ready_cyc));
      if (ev) begin
        chk("rsp_hit", 32'(rsp_hit), 32'(exp_r.hit));
        chk("rsp_way", 32'(rsp_way), 32'(exp_r.way));
        chk("bus_rd", 32'(rsp_bus_rd), 32'(exp_r.rd));
        chk("bus_rwim", 32'(rsp_bus_rwim), 32'(exp_r.rwim));
        chk("bus_inv", 32'(rsp_bus_inv), 32'(exp_r.inv));
        chk("writeback", 32'(rsp_writeback), 32'(exp_r.wb));
        chk("wb_tag", 32'(rsp_wb_tag), 32'(exp_r.wbt));
        chk("snoop", 32'(rsp_snoop_result), 32'(exp_r.snp));
      end
    end
  end

  task automatic send(input logic [3:0] op,
                      input int s,
                      input logic [21:0] tg,
                      input logic sh,
                      output exp_t r);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (!req_ready && n < 64) begin
      @(negedge clk); #1;
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    r = m_apply(op, s, tg, sh);
    exp_r = r;
    exp_cyc   = cyc + ((op == 4'd8) ? NS : 2);
    ready_cyc = cyc + ((op == 4'd8) ? NS + 1 : 3);
    req_op = op;
    req_index = 4'(s);
    req_tag = tg;
    req_snoop_hit = sh;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Called #1 after the accept edge; k further edges land mid-operation.
  task automatic reset_after(input int k);
    repeat (k) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_cyc = -10;
    ready_cyc = cyc + 1;
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_op = '0;
    req_index = '0;
    req_tag = '0;
    req_snoop_hit = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    ready_cyc = cyc;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_hit", 32'(rsp_hit), 32'd0);
    chk("rst_way", 32'(rsp_way), 32'd0);
    chk("rst_bus", 32'({rsp_bus_rd, rsp_bus_rwim, rsp_bus_inv}),
        32'd0);
    chk("rst_wb", 32'({rsp_writeback, rsp_wb_tag}), 32'd0);
    chk("rst_snoop", 32'(rsp_snoop_result), 32'd0);
    chk_en = 1'b1;

    send(4'd0, 3, 22'h1A, 1'b0, e);
    chk("lit_miss_rd", 32'({e.hit, e.way, e.rd}), 32'b0001);
    send(4'd0, 3, 22'h1A, 1'b0, e);
    chk("lit_hit_rd", 32'({e.hit, e.way, e.rd}), 32'b1000);
    chk("lit_state_E", 32'(m_st[3][0]), 32'd2);
    send(4'd1, 3, 22'h1A, 1'b0, e);
    chk("lit_wr_hit", 32'({e.hit, e.rwim, e.inv}), 32'b100);
    chk("lit_state_M", 32'(m_st[3][0]), 32'd3);
    send(4'd4, 3, 22'h1A, 1'b0, e);
    chk("lit_snp_hitm", 32'({e.snp, e.wb}), 32'b101);
    chk("lit_snp_wbtag", 32'(e.wbt), 32'h1A);

    send(4'd0, 5, 22'h100, 1'b0, e);
    send(4'd2, 5, 22'h101, 1'b0, e);
    send(4'd1, 5, 22'h102, 1'b0, e);
    chk("lit_rwim", 32'({e.way, e.rwim}), 32'b101);
    send(4'd0, 5, 22'h103, 1'b0, e);
    send(4'd0, 5, 22'h100, 1'b0, e);
    send(4'd0, 5, 22'h104, 1'b0, e);
    chk("lit_plru_vic", 32'({e.hit, e.way, e.rd}), 32'b0101);
    chk("lit_vic_wb", 32'({e.wb, e.wbt}), 32'({1'b1, 22'h102}));

    send(4'd6, 3, 22'h1A, 1'b0, e);
    chk("lit_rwim_S", 32'({e.hit, e.snp}), 32'b101);
    send(4'd0, 3, 22'h1A, 1'b0, e);
    chk("lit_after_rwim", 32'({e.hit, e.way}), 32'd0);
    send(4'd0, 7, 22'h55, 1'b1, e);
    send(4'd3, 7, 22'h55, 1'b0, e);
    chk("lit_inv_S", 32'({e.hit, e.snp}), 32'b101);
    send(4'd0, 7, 22'h55, 1'b0, e);
    chk("lit_after_inv", 32'(e.hit), 32'd0);
    send(4'd3, 5, 22'h104, 1'b0, e);
    chk("lit_inv_E", 32'({e.hit, e.snp}), 32'b100);
    send(4'd4, 5, 22'h999, 1'b0, e);
    chk("lit_snp_miss", 32'({e.hit, e.snp, e.wb}), 32'd0);
    send(4'd0, 5, 22'h105, 1'b0, e);
    chk("lit_plru_kept", 32'({e.way, e.wb}), 32'b010);
    send(4'd0, 8, 22'h77, 1'b1, e);
    send(4'd1, 8, 22'h77, 1'b0, e);
    chk("lit_wr_S", 32'({e.hit, e.inv}), 32'b11);
    send(4'd5, 8, 22'h77, 1'b0, e);
    chk("lit_unknown", 32'(e), 32'd0);

    send(4'd8, 0, 22'h0, 1'b0, e);
    send(4'd0, 5, 22'h100, 1'b0, e);
    chk("lit_clr_5", 32'({e.hit, e.way}), 32'd0);
    send(4'd0, 3, 22'h1A, 1'b0, e);
    chk("lit_clr_3", 32'({e.hit, e.way}), 32'd0);

    send(4'd0, 9, 22'h3, 1'b0, e);
    reset_after(1);
    send(4'd1, 3, 22'h1A, 1'b0, e);
    chk("lit_rst_upd", 32'({e.hit, e.rwim}), 32'b01);
    send(4'd8, 0, 22'h0, 1'b0, e);
    reset_after(7);
`ifdef LLC_STATS_EN
    @(negedge clk);
    chk("stat_reads", stat_reads, 32'd0);
    chk("stat_writes", stat_writes, 32'd0);
    chk("stat_hits", stat_hits, 32'd0);
    chk("stat_misses", stat_misses, 32'd0);
`endif
    send(4'd0, 3, 22'h1A, 1'b0, e);
    chk("lit_rst_clr", 32'({e.hit, e.way, e.rd}), 32'b0001);

    for (int i = 0; i < 40 && cyc <= exp_cyc; i++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
